// File: rtl/fnd_scan_sequencer.sv
// Scan sequencer for the 4-digit FND display.
// Rotates a one-hot digit select across four digits at SCAN_DIV cycles per slot.
// The display enable is held off for the first GUARD cycles of every slot.
// New display content arrives through a single pending buffer.
// Pending content is promoted to the active set only at a frame boundary, or while idle.
//
// Handshake: a transfer happens on a rising PCLK edge when upd_valid && upd_ready.
// The producer holds upd_data/upd_dp/upd_den stable while upd_valid is high and
// upd_ready is low. upd_ready is combinational: the buffer is free, or it empties
// (apply) in this same cycle.
module fnd_scan_sequencer #(
  parameter int SCAN_DIV = 100_000,
  parameter int GUARD    = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        en,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_data,
  input  logic [3:0]  upd_dp,
  input  logic [3:0]  upd_den,
  output logic        fcr,
  output logic [3:0]  fmr,
  output logic [3:0]  fdr,
  output logic        fdp,
  output logic        frame_done,
  output logic        dbg_state
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

  typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic             r_pend_full;
  logic [15:0]      r_pend_data;
  logic [3:0]       r_pend_dp;
  logic [3:0]       r_pend_den;
  logic [15:0]      r_act_data;
  logic [3:0]       r_act_dp;
  logic [3:0]       r_act_den;
  logic             r_fcr;
  logic [3:0]       r_fmr;
  logic [3:0]       r_fdr;
  logic             r_fdp;
  logic             r_frame_done;

  logic             w_tick;
  logic             w_apply;
  logic             w_xfer;
  logic             w_frame_end;
  state_t           w_nxt_state;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [1:0]       w_nxt_idx;
  logic [15:0]      w_nxt_data;
  logic [3:0]       w_nxt_dp;
  logic [3:0]       w_nxt_den;
  logic             w_nxt_fcr;
  logic [3:0]       w_nxt_fmr;
  logic [3:0]       w_nxt_fdr;
  logic             w_nxt_fdp;

  // Slot tick, frame end, and the pending-buffer handshake terms
  assign w_tick      = (r_state == ST_SCAN) && (r_cnt == CNT_MAX);
  assign w_frame_end = w_tick && (r_idx == 2'd3);
  assign w_apply     = r_pend_full && ((r_state == ST_IDLE) || w_frame_end);
  assign upd_ready   = !r_pend_full || w_apply;
  assign w_xfer      = upd_valid && upd_ready;

  // Active content seen from the next cycle onward
  assign w_nxt_data = w_apply ? r_pend_data : r_act_data;
  assign w_nxt_dp   = w_apply ? r_pend_dp   : r_act_dp;
  assign w_nxt_den  = w_apply ? r_pend_den  : r_act_den;

  // Next state and slot position; leaving or entering SCAN restarts at digit 0
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = '0;
    w_nxt_idx   = 2'd0;
    if (r_state == ST_IDLE) begin
      if (en) w_nxt_state = ST_SCAN;
    end else if (!en) begin
      w_nxt_state = ST_IDLE;
    end else if (w_tick) begin
      w_nxt_idx = r_idx + 2'd1;
    end else begin
      w_nxt_cnt = r_cnt + CNT_W'(1);
      w_nxt_idx = r_idx;
    end
  end

  // Display outputs for the upcoming slot position, so the registered copies line up with cnt/idx
  always_comb begin
    w_nxt_fcr = 1'b0;
    w_nxt_fmr = 4'b0000;
    w_nxt_fdr = 4'h0;
    w_nxt_fdp = 1'b0;
    if (w_nxt_state == ST_SCAN) begin
      w_nxt_fmr = 4'b0001 << w_nxt_idx;
      w_nxt_fdr = w_nxt_data[{w_nxt_idx, 2'b00} +: 4];
      w_nxt_fdp = w_nxt_dp[w_nxt_idx];
      w_nxt_fcr = (w_nxt_cnt >= CNT_GUARD) && w_nxt_den[w_nxt_idx];
    end
  end

  // State, counters, buffers and registered outputs
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_pend_full  <= 1'b0;
      r_pend_data  <= 16'h0000;
      r_pend_dp    <= 4'h0;
      r_pend_den   <= 4'h0;
      r_act_data   <= 16'h0000;
      r_act_dp     <= 4'h0;
      r_act_den    <= 4'h0;
      r_fcr        <= 1'b0;
      r_fmr        <= 4'h0;
      r_fdr        <= 4'h0;
      r_fdp        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_idx      <= w_nxt_idx;
      r_act_data <= w_nxt_data;
      r_act_dp   <= w_nxt_dp;
      r_act_den  <= w_nxt_den;
      if (w_xfer) begin
        r_pend_data <= upd_data;
        r_pend_dp   <= upd_dp;
        r_pend_den  <= upd_den;
        r_pend_full <= 1'b1;
      end else if (w_apply) begin
        r_pend_full <= 1'b0;
      end
      r_fcr        <= w_nxt_fcr;
      r_fmr        <= w_nxt_fmr;
      r_fdr        <= w_nxt_fdr;
      r_fdp        <= w_nxt_fdp;
      // A frame only completes if scanning continues past the wrap
      r_frame_done <= (r_state == ST_SCAN) && en && w_frame_end;
    end
  end

  assign fcr        = r_fcr;
  assign fmr        = r_fmr;
  assign fdr        = r_fdr;
  assign fdp        = r_fdp;
  assign frame_done = r_frame_done;
  assign dbg_state  = (r_state == ST_SCAN);

endmodule

// File: tb/tb_fnd_scan_sequencer.sv
// Bench for fnd_scan_sequencer with SCAN_DIV=8, GUARD=2.
// The reference model tracks time since scanning began plus an active set and a pending queue.
// Digit position, guard and frame end all follow from that time value by division.
module tb_fnd_scan_sequencer;

  localparam int SD = 8;
  localparam int GD = 2;

  // ---------------- clock / reset ----------------
  logic        PCLK      = 1'b0;
  logic        PRESET    = 1'b0;
  logic        en        = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data  = 16'h0000;
  logic [3:0]  upd_dp    = 4'h0;
  logic [3:0]  upd_den   = 4'h0;
  logic        upd_ready;
  logic        fcr;
  logic [3:0]  fmr;
  logic [3:0]  fdr;
  logic        fdp;
  logic        frame_done;
  logic        dbg_state;

  always #5 PCLK = ~PCLK;

  fnd_scan_sequencer #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .en(en),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_data(upd_data), .upd_dp(upd_dp), .upd_den(upd_den),
    .fcr(fcr), .fmr(fmr), .fdr(fdr), .fdp(fdp),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  bit          m_scan;
  int          m_t;
  logic [15:0] a_data;
  logic [3:0]  a_dp;
  logic [3:0]  a_den;
  logic [23:0] exp_q[$];
  bit          m_fd;
  bit          m_last_xfer;
  bit          chk_on;
  int          n_vec;
  int          n_err;

  function automatic int m_idx();
    return (m_t / SD) % 4;
  endfunction

  function automatic int m_cnt();
    return m_t % SD;
  endfunction

  function automatic bit m_eof();
    return m_scan && (m_cnt() == SD - 1) && (m_idx() == 3);
  endfunction

  function automatic bit m_apply();
    return (exp_q.size() != 0) && (!m_scan || m_eof());
  endfunction

  function automatic bit m_ready();
    return (exp_q.size() == 0) || m_apply();
  endfunction

  task automatic model_reset();
    m_scan = 1'b0;
    m_t = 0;
    a_data = 16'h0000;
    a_dp = 4'h0;
    a_den = 4'h0;
    exp_q.delete();
    m_fd = 1'b0;
    m_last_xfer = 1'b0;
  endtask

  task automatic model_edge();
    bit app;
    bit rdy;
    logic [23:0] ent;
    app = m_apply();
    rdy = m_ready();
    m_fd = m_scan && en && m_eof();
    if (app) begin
      ent = exp_q.pop_front();
      {a_den, a_dp, a_data} = ent;
    end
    m_last_xfer = upd_valid && rdy;
    if (m_last_xfer) exp_q.push_back({upd_den, upd_dp, upd_data});
    if (en) begin
      m_t = m_scan ? m_t + 1 : 0;
      m_scan = 1'b1;
    end else begin
      m_scan = 1'b0;
      m_t = 0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every cycle: DUT outputs against the model
  always @(negedge PCLK) begin
    int i;
    if (PRESET && chk_on) begin
      i = m_idx();
      check("fcr",        32'(fcr),        32'(m_scan && (m_cnt() >= GD) && a_den[i]));
      check("fmr",        32'(fmr),        m_scan ? 32'(1 << i) : 32'd0);
      check("fdr",        32'(fdr),        m_scan ? 32'(a_data[i*4 +: 4]) : 32'd0);
      check("fdp",        32'(fdp),        32'(m_scan && a_dp[i]));
      check("frame_done", 32'(frame_done), 32'(m_fd));
      check("upd_ready",  32'(upd_ready),  32'(m_ready()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge PCLK);
    if (PRESET) model_edge();
    else model_reset();
    #1;
  endtask

  task automatic wait_slot(input int idx, input int cnt);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_scan && m_idx() == idx && m_cnt() == cnt) && n < 200);
    if (!(m_scan && m_idx() == idx && m_cnt() == cnt)) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_slot timeout: wanted idx %0d cnt %0d", idx, cnt);
    end
  endtask

  task automatic wait_xfer();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_last_xfer && n < 100);
    if (!m_last_xfer) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_xfer timeout");
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] den);
    upd_valid = 1'b1;
    upd_data = d;
    upd_dp = dp;
    upd_den = den;
    wait_xfer();
    upd_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    chk_on = 1'b0;
    model_reset();
    repeat (3) step();
    check("rst_fcr", 32'(fcr), 0);
    check("rst_fmr", 32'(fmr), 0);
    check("rst_fdr", 32'(fdr), 0);
    check("rst_fdp", 32'(fdp), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_upd_ready", 32'(upd_ready), 1);
    PRESET = 1'b1;
    chk_on = 1'b1;
    step();

    // 1: load 4321 while idle, then scan
    upd_valid = 1'b1; upd_data = 16'h4321; upd_dp = 4'h0; upd_den = 4'hF;
    step();
    upd_valid = 1'b0;
    step();
    en = 1'b1;
    step();
    check("s1_fmr_slot0", 32'(fmr), 32'h1);
    check("s1_fdr_slot0", 32'(fdr), 32'h1);
    check("s1_fcr_guard", 32'(fcr), 0);
    repeat (2) step();
    check("s1_fcr_after_guard", 32'(fcr), 1);
    repeat (6) step();
    check("s1_fmr_slot1", 32'(fmr), 32'h2);
    check("s1_fdr_slot1", 32'(fdr), 32'h2);
    repeat (24) step();
    check("s1_frame_done", 32'(frame_done), 1);
    check("s1_fmr_wrap", 32'(fmr), 32'h1);

    // 2: mid-frame update takes effect at the next frame
    wait_slot(1, 2);
    send(16'hABCD, 4'h0, 4'hF);
    check("s2_ready_low", 32'(upd_ready), 0);
    wait_slot(2, GD);
    check("s2_old_digit2", 32'(fdr), 32'h3);
    wait_slot(3, GD);
    check("s2_old_digit3", 32'(fdr), 32'h4);
    wait_slot(0, 0);
    check("s2_new_digit0", 32'(fdr), 32'hD);
    check("s2_ready_back", 32'(upd_ready), 1);

    // 3: valid held while the buffer is full; second transfer on the apply edge
    wait_slot(1, 0);
    upd_valid = 1'b1; upd_data = 16'h5678; upd_dp = 4'h0; upd_den = 4'hF;
    wait_xfer();
    upd_data = 16'h9ABC;
    wait_xfer();
    upd_valid = 1'b0;
    check("s3_boundary_fmr", 32'(fmr), 32'h1);
    check("s3_first_payload", 32'(fdr), 32'h8);
    check("s3_ready_full", 32'(upd_ready), 0);
    wait_slot(0, 0);
    check("s3_second_payload", 32'(fdr), 32'hC);

    // 4: blanked digits and a single decimal point
    send(16'h1234, 4'b0001, 4'b1010);
    wait_slot(0, 0);
    wait_slot(0, 3);
    check("s4_slot0_fcr", 32'(fcr), 0);
    check("s4_slot0_fdp", 32'(fdp), 1);
    check("s4_slot0_fdr", 32'(fdr), 32'h4);
    wait_slot(1, 3);
    check("s4_slot1_fcr", 32'(fcr), 1);
    check("s4_slot1_fdp", 32'(fdp), 0);
    wait_slot(2, 5);
    check("s4_slot2_fcr", 32'(fcr), 0);

    // 5: drop en mid-slot, then restart
    en = 1'b0;
    step();
    check("s5_dark_fcr", 32'(fcr), 0);
    check("s5_dark_fmr", 32'(fmr), 0);
    check("s5_no_frame_done", 32'(frame_done), 0);
    en = 1'b1;
    step();
    check("s5_restart_fmr", 32'(fmr), 32'h1);
    check("s5_restart_fdr", 32'(fdr), 32'h4);

    // 6: reset while an update is pending at idx 3
    send(16'h4321, 4'h0, 4'hF);
    wait_slot(0, 0);
    wait_slot(3, 1);
    upd_valid = 1'b1; upd_data = 16'hDEAD; upd_dp = 4'hF; upd_den = 4'hF;
    step();
    upd_valid = 1'b0;
    step();
    #2;
    PRESET = 1'b0;
    model_reset();
    #1;
    check("s6_rst_fcr", 32'(fcr), 0);
    check("s6_rst_fmr", 32'(fmr), 0);
    check("s6_rst_fdr", 32'(fdr), 0);
    check("s6_rst_ready", 32'(upd_ready), 1);
    step();
    PRESET = 1'b1;
    step();
    check("s6_after_fmr", 32'(fmr), 32'h1);
    check("s6_after_fdr", 32'(fdr), 32'h0);
    check("s6_after_ready", 32'(upd_ready), 1);
    repeat (40) step();

    // Random phase: occasional en toggles, producer holds unaccepted data
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      if (!(upd_valid && !m_last_xfer)) begin
        upd_valid = ($urandom_range(0, 9) == 0);
        upd_data = 16'($urandom);
        upd_dp = 4'($urandom_range(0, 15));
        upd_den = 4'($urandom_range(0, 15));
      end
      step();
    end
    upd_valid = 1'b0;
    en = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
